// File: rtl/graph_mem_pkg.sv
// Shared types for the graph memory arbiter.
// Tag bundle carried alongside each in-flight BRAM read.
package graph_mem_pkg;

  localparam int GM_ADDR_W    = 32;
  localparam int GM_PROC_BITS = 4;

  typedef enum logic {
    REQ_ROWIDX = 1'b0,
    REQ_DATA   = 1'b1
  } req_kind_e;

  typedef struct packed {
    logic                    valid;
    logic [GM_PROC_BITS-1:0] id;
  } mem_tag_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first request at or after ptr.
// Wraps modulo N; N must be 2**W.
module rr_picker #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] j;

  // scan from ptr, keep the first hit
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = ptr + W'(k);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Shares graph_memory among NUM_PROC walkers.
// RR grant per port, tagged fixed-latency return.
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter int NUM_PROC  = 16,
  parameter int PROC_BITS = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_PROC-1:0]     req_valid,
  input  logic [NUM_PROC-1:0]     req_kind,
  input  logic [NUM_PROC*32-1:0]  req_addr,
  output logic [NUM_PROC-1:0]     req_ready,
  output logic [32+PROC_BITS-1:0] idx_addr,
  output logic                    idx_validin,
  output logic [32+PROC_BITS-1:0] data_addra,
  output logic [32+PROC_BITS-1:0] data_addrb,
  output logic                    data_validina,
  output logic                    data_validinb,
  input  logic [31:0]             rowidx_out,
  input  logic [31:0]             data_outa,
  input  logic [31:0]             data_outb,
  output logic [NUM_PROC-1:0]     resp_valid,
  output logic [NUM_PROC*32-1:0]  resp_data
);

  localparam int AW = GM_ADDR_W;
  localparam int TW = AW + PROC_BITS;
  localparam int NP = 3;

  logic [NUM_PROC-1:0]  cand_idx, cand_dat, mask_b;
  logic [NUM_PROC-1:0]  gnt_i, gnt_a, gnt_b;
  logic [PROC_BITS-1:0] idx_i, idx_a, idx_b, ptr_b;
  logic                 found_i, found_a, found_b;

  logic [PROC_BITS-1:0] rr_idx_q, rr_idx_d;
  logic [PROC_BITS-1:0] rr_data_q, rr_data_d;

  logic          iss_valid_q [NP];
  logic          iss_valid_d [NP];
  logic [TW-1:0] iss_addr_q  [NP];
  logic [TW-1:0] iss_addr_d  [NP];

  mem_tag_t tag_q [NP][MEM_LAT];
  mem_tag_t tag_d [NP][MEM_LAT];

  logic [AW-1:0] mem_rd [NP];

  logic [NUM_PROC-1:0]    resp_valid_q, resp_valid_d;
  logic [NUM_PROC*32-1:0] resp_data_q, resp_data_d;

  // split requests by kind
  always_comb begin
    cand_idx = '0;
    cand_dat = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      cand_dat[i] = req_valid[i] &
        (req_kind_e'(req_kind[i]) == REQ_DATA);
      cand_idx[i] = req_valid[i] &
        (req_kind_e'(req_kind[i]) == REQ_ROWIDX);
    end
  end

  assign mask_b = cand_dat & ~gnt_a;
  assign ptr_b  = idx_a + PROC_BITS'(1);

  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_i (
    .req   (cand_idx),
    .ptr   (rr_idx_q),
    .grant (gnt_i),
    .idx   (idx_i),
    .found (found_i)
  );

  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_a (
    .req   (cand_dat),
    .ptr   (rr_data_q),
    .grant (gnt_a),
    .idx   (idx_a),
    .found (found_a)
  );

  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_b (
    .req   (mask_b),
    .ptr   (ptr_b),
    .grant (gnt_b),
    .idx   (idx_b),
    .found (found_b)
  );

  assign req_ready = (gnt_i | gnt_a | gnt_b) & {NUM_PROC{rst_n_in}};

  // pointer advance and issue register next state
  always_comb begin
    rr_idx_d = found_i ? idx_i + PROC_BITS'(1) : rr_idx_q;
    rr_data_d = rr_data_q;
    if (found_b)      rr_data_d = idx_b + PROC_BITS'(1);
    else if (found_a) rr_data_d = idx_a + PROC_BITS'(1);

    iss_valid_d[0] = found_i;
    iss_valid_d[1] = found_a;
    iss_valid_d[2] = found_b;
    iss_addr_d[0]  = found_i ?
      {idx_i, req_addr[AW*idx_i +: AW]} : iss_addr_q[0];
    iss_addr_d[1]  = found_a ?
      {idx_a, req_addr[AW*idx_a +: AW]} : iss_addr_q[1];
    iss_addr_d[2]  = found_b ?
      {idx_b, req_addr[AW*idx_b +: AW]} : iss_addr_q[2];
  end

  assign mem_rd[0] = rowidx_out;
  assign mem_rd[1] = data_outa;
  assign mem_rd[2] = data_outb;

  // tag shift and response steering
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    for (int p = 0; p < NP; p++) begin
      tag_d[p][0].valid = iss_valid_q[p];
      tag_d[p][0].id    = iss_addr_q[p][AW +: GM_PROC_BITS];
      for (int s = 1; s < MEM_LAT; s++)
        tag_d[p][s] = tag_q[p][s-1];
      if (tag_q[p][MEM_LAT-1].valid) begin
        resp_valid_d[tag_q[p][MEM_LAT-1].id] = 1'b1;
        resp_data_d[AW*tag_q[p][MEM_LAT-1].id +: AW] = mem_rd[p];
      end
    end
  end

  // state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_idx_q     <= '0;
      rr_data_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      for (int p = 0; p < NP; p++) begin
        iss_valid_q[p] <= 1'b0;
        iss_addr_q[p]  <= '0;
        for (int s = 0; s < MEM_LAT; s++)
          tag_q[p][s] <= '0;
      end
    end else begin
      rr_idx_q     <= rr_idx_d;
      rr_data_q    <= rr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int p = 0; p < NP; p++) begin
        iss_valid_q[p] <= iss_valid_d[p];
        iss_addr_q[p]  <= iss_addr_d[p];
        for (int s = 0; s < MEM_LAT; s++)
          tag_q[p][s] <= tag_d[p][s];
      end
    end
  end

  // no requester may appear on two ports at one stage
  always @(posedge clk_in) begin
    if (rst_n_in) begin
      for (int s = 0; s < MEM_LAT; s++)
        for (int p = 0; p < NP; p++)
          for (int q = p + 1; q < NP; q++)
            assert (!(tag_q[p][s].valid && tag_q[q][s].valid &&
                      tag_q[p][s].id == tag_q[q][s].id));
    end
  end

  assign idx_validin   = iss_valid_q[0];
  assign data_validina = iss_valid_q[1];
  assign data_validinb = iss_valid_q[2];
  assign idx_addr      = iss_addr_q[0];
  assign data_addra    = iss_addr_q[1];
  assign data_addrb    = iss_addr_q[2];
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter.
// Two-cycle BRAM model feeds the read ports.
module tb_graph_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic [15:0]  req_valid;
  logic [15:0]  req_kind;
  logic [511:0] req_addr;
  logic [15:0]  req_ready;
  logic [35:0]  idx_addr, data_addra, data_addrb;
  logic         idx_validin, data_validina, data_validinb;
  logic [31:0]  rowidx_out, data_outa, data_outb;
  logic [15:0]  resp_valid;
  logic [511:0] resp_data;
  logic [31:0]  m1_i, m1_a, m1_b;

  int checks = 0;
  int errors = 0;

  graph_mem_arbiter dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid     (req_valid),
    .req_kind      (req_kind),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .idx_addr      (idx_addr),
    .idx_validin   (idx_validin),
    .data_addra    (data_addra),
    .data_addrb    (data_addrb),
    .data_validina (data_validina),
    .data_validinb (data_validinb),
    .rowidx_out    (rowidx_out),
    .data_outa     (data_outa),
    .data_outb     (data_outb),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // row memory: a ^ A5A50000, edge memory: a + 10000000
  always @(posedge clk) begin
    m1_i       <= idx_addr[31:0] ^ 32'hA5A5_0000;
    m1_a       <= data_addra[31:0] + 32'h1000_0000;
    m1_b       <= data_addrb[31:0] + 32'h1000_0000;
    rowidx_out <= m1_i;
    data_outa  <= m1_a;
    data_outb  <= m1_b;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic k,
                         input logic [31:0] a);
    req_valid[i]       = 1'b1;
    req_kind[i]        = k;
    req_addr[32*i +: 32] = a;
  endtask

  function automatic logic [31:0] lane(input int i);
    return resp_data[32*i +: 32];
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_kind  = '0;
    req_addr  = '0;
    #12;
    check("rst_ready", req_ready, 16'h0);
    check("rst_rvalid", resp_valid, 16'h0);
    check("rst_ivalid", idx_validin, 1'b0);
    check("rst_iaddr", idx_addr, 36'h0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single row-index read
    set_req(3, 1'b0, 32'h10);
    #1;
    check("t1_ready", req_ready, 16'h0008);
    tick();
    req_valid = '0;
    check("t1_ivalid", idx_validin, 1'b1);
    check("t1_iaddr", idx_addr, {4'd3, 32'h10});
    tick();
    check("t1_ivalid_pulse", idx_validin, 1'b0);
    check("t1_iaddr_hold", idx_addr, {4'd3, 32'h10});
    tick();
    check("t1_rv_t3", resp_valid, 16'h0);
    tick();
    check("t1_rv_t4", resp_valid, 16'h0008);
    check("t1_rd_t4", lane(3), 32'hA5A5_0010);
    tick();
    check("t1_rv_t5", resp_valid, 16'h0);

    // data rr: procs 1,5,9
    set_req(1, 1'b1, 32'h101);
    set_req(5, 1'b1, 32'h105);
    set_req(9, 1'b1, 32'h109);
    #1;
    check("t2_ready0", req_ready, 16'h0022);
    tick();
    check("t2_va", data_validina, 1'b1);
    check("t2_aa", data_addra, {4'd1, 32'h101});
    check("t2_vb", data_validinb, 1'b1);
    check("t2_ab", data_addrb, {4'd5, 32'h105});
    req_valid[1] = 1'b0;
    req_valid[5] = 1'b0;
    #1;
    check("t2_ready1", req_ready, 16'h0200);
    tick();
    check("t2_aa1", data_addra, {4'd9, 32'h109});
    check("t2_vb1", data_validinb, 1'b0);
    set_req(11, 1'b1, 32'h10B);
    #1;
    check("t2_ready2", req_ready, 16'h0A00);
    tick();
    req_valid = '0;
    check("t2_aa2", data_addra, {4'd11, 32'h10B});
    check("t2_ab2", data_addrb, {4'd9, 32'h109});
    tick();
    check("t2_rv4", resp_valid, 16'h0022);
    check("t2_rd1", lane(1), 32'h1000_0101);
    check("t2_rd5", lane(5), 32'h1000_0105);
    tick();
    check("t2_rv5", resp_valid, 16'h0200);
    check("t2_rd9", lane(9), 32'h1000_0109);
    tick();
    check("t2_rv6", resp_valid, 16'h0A00);
    check("t2_rd11", lane(11), 32'h1000_010B);
    tick();

    // all 16 row-index requesters from a clean pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) set_req(i, 1'b0, 32'(i));
    #1;
    for (int k = 0; k < 16; k++) begin
      check("t3_rr", req_ready, 16'(1) << k);
      tick();
    end
    check("t3_wrap", req_ready, 16'h0001);
    req_valid = '0;
    repeat (6) tick();

    // mixed traffic
    set_req(2, 1'b0, 32'h20);
    set_req(4, 1'b1, 32'h40);
    set_req(7, 1'b1, 32'h70);
    #1;
    check("t4_ready", req_ready, 16'h0094);
    tick();
    req_valid = '0;
    check("t4_valids",
          {idx_validin, data_validina, data_validinb}, 3'b111);
    repeat (3) tick();
    check("t4_rv", resp_valid, 16'h0094);
    check("t4_rd2", lane(2), 32'hA5A5_0020);
    check("t4_rd4", lane(4), 32'h1000_0040);
    check("t4_rd7", lane(7), 32'h1000_0070);
    tick();

    // back-to-back data reads from proc 0
    for (int n = 0; n < 3; n++) begin
      set_req(0, 1'b1, 32'(n));
      #1;
      check("t5_ready", req_ready, 16'h0001);
      tick();
    end
    req_valid = '0;
    tick();
    for (int n = 0; n < 3; n++) begin
      check("t5_rv", resp_valid, 16'h0001);
      check("t5_rd", lane(0), 32'h1000_0000 + 32'(n));
      tick();
    end
    check("t5_rv_end", resp_valid, 16'h0);

    // reset with a read in flight
    set_req(3, 1'b0, 32'h30);
    #1;
    check("t6_ready", req_ready, 16'h0008);
    tick();
    req_valid = '0;
    check("t6_ivalid", idx_validin, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_iv", idx_validin, 1'b0);
    check("t6_rst_ia", idx_addr, 36'h0);
    check("t6_rst_aa", data_addra, 36'h0);
    check("t6_rst_rv", resp_valid, 16'h0);
    check("t6_rst_rd", resp_data[63:0], 64'h0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t6_stale", resp_valid, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
